output_bram_streamer: RTL and testbench
=======================================

OUTPUT_BRAM_STREAMER -- requirements
Module: output_bram_streamer

Interface
REQ-001 Parameter OUT_WIDTH, default 126, output columns per row.
REQ-002 Parameter OUT_HEIGHT, default 126, output rows.
REQ-003 Parameter DATA_WIDTH, default 32, result word width.
REQ-004 Parameter ADDR_WIDTH, default 14, output BRAM address width.
REQ-005 Parameter READ_LATENCY, default 2, BRAM read latency in cycles from address to valid dout.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 start  input  1  one-cycle request to stream the full result frame.
REQ-009 bram_en  output  1  output BRAM port-A enable (read only).
REQ-010 bram_addr  output  ADDR_WIDTH  output BRAM read address.
REQ-011 bram_dout  input  DATA_WIDTH  output BRAM read data.
REQ-012 m_data  output  DATA_WIDTH  streamed result word.
REQ-013 m_valid  output  1  m_data valid.
REQ-014 m_ready  input  1  downstream accepts beat when m_valid and m_ready both high.
REQ-015 m_row_last  output  1  high with last beat of each output row.
REQ-016 m_last  output  1  high with final beat of the frame.
REQ-017 busy  output  1  high from start acceptance until done.
REQ-018 done  output  1  one-cycle pulse after the final beat handshakes.

Function
REQ-019 Frame length N = OUT_WIDTH*OUT_HEIGHT; addresses 0..N-1 read in ascending order, row-major.
REQ-020 FSM states IDLE, READ, FLUSH, DONE; IDLE->READ on start; READ->FLUSH after address N-1 issued; FLUSH->DONE on handshake of beat N-1; DONE->IDLE unconditionally after one cycle.
REQ-021 start is ignored in any state other than IDLE.
REQ-022 bram_en and bram_addr are registered; bram_en=1 only in cycles where a read is issued; bram_addr=0 when no read is issued.
REQ-023 Each issued read is tracked by a READ_LATENCY-deep valid pipeline; bram_dout is written into a 4-entry output FIFO exactly READ_LATENCY cycles after the cycle its address is driven.
REQ-024 A read is issued in a cycle only if FIFO occupancy plus in-flight reads is < 4; FIFO never overflows and no read is ever dropped or duplicated.
REQ-025 m_data/m_valid are driven from the FIFO head; m_valid is high iff FIFO is non-empty; head pops only on m_valid && m_ready.
REQ-026 With m_ready held high, beats are delivered one per cycle with no bubbles after the first beat.
REQ-027 First m_valid rises READ_LATENCY+1 cycles after the edge sampling start (3 cycles at default).
REQ-028 m_data and m_valid remain stable while m_valid && !m_ready.
REQ-029 m_row_last is high on beat k iff (k mod OUT_WIDTH) = OUT_WIDTH-1; m_last is high only on beat N-1 (m_row_last also high then).
REQ-030 FIFO push and pop in the same cycle leave occupancy unchanged.
REQ-031 busy is high in READ, FLUSH and DONE; done is high only in DONE.
REQ-032 A second start in the DONE cycle is ignored; start in the following IDLE cycle begins a new frame from address 0.

Reset
REQ-033 On rst high at any clock edge, state=IDLE, FIFO and in-flight pipeline cleared, address counter=0.
REQ-034 Reset values: bram_en=0, bram_addr=0, m_data=0, m_valid=0, m_row_last=0, m_last=0, busy=0, done=0.
REQ-035 Reset mid-frame discards all in-flight reads; no beat from the aborted frame appears after reset deasserts.

Verification
REQ-036 BRAM model preloaded mem[i]=i, m_ready=1, start pulse -> 15876 beats m_data=0..15875 consecutive, first m_valid 3 cycles after start, done pulse one cycle after beat 15875.
REQ-037 Same preload, m_ready random 50% -> identical data sequence, no lost/duplicated beats, m_data stable during stalls, bram reads never exceed 4 outstanding.
REQ-038 OUT_WIDTH=4, OUT_HEIGHT=3 -> m_row_last on beats 3,7,11; m_last only on beat 11; done exactly once.
REQ-039 m_ready held 0 for 100 cycles after start -> exactly 4 bram reads issued, m_valid high with m_data=0 throughout; release -> stream resumes 0,1,2,...
REQ-040 rst asserted at beat 500 for 1 cycle -> all outputs reset values next cycle; subsequent start streams from address 0 with no stale beats.
REQ-041 start pulsed during READ and DONE -> ignored; frame length stays 15876, done pulses once.

Source files
------------

// File: rtl/output_bram_streamer_if.sv
// BRAM read port plus result stream of output_bram_streamer.
// The master side is the streamer; the slave side is the BRAM and stream sink.
interface output_bram_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    logic                  bram_en;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_dout;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_row_last;
    logic                  m_last;

    modport master (
        output bram_en, bram_addr, m_data, m_valid, m_row_last, m_last,
        input  bram_dout, m_ready
    );
    modport slave (
        input  bram_en, bram_addr, m_data, m_valid, m_row_last, m_last,
        output bram_dout, m_ready
    );
endinterface

// File: rtl/output_bram_streamer.sv
// Streams a row-major result frame out of a BRAM with fixed read latency,
// buffering returned words in a 4-entry FIFO under credit-based read issue.
module output_bram_streamer #(
    parameter int OUT_WIDTH    = 126,
    parameter int OUT_HEIGHT   = 126,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output_bram_streamer_if.master bus,
    output logic                   busy,
    output logic                   done
);
    localparam int FRAME_LEN = OUT_WIDTH * OUT_HEIGHT;
    localparam int COL_BITS  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [COL_BITS-1:0]   LAST_COL  = COL_BITS'(OUT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] beat_cnt;
    logic [COL_BITS-1:0]   col_cnt;
    logic [READ_LATENCY:0] rd_pipe;
    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_cnt;
    logic [7:0]            outstanding;
    logic                  issue, push, pop, fifo_valid;

    assign fifo_valid = (fifo_cnt != 3'd0);
    assign push       = rd_pipe[READ_LATENCY];
    assign pop        = fifo_valid && bus.m_ready;

    // rd_pipe[0] is the read on the bus this cycle; the last stage pushes.
    // Counting the pop lets a full-rate stream keep issuing without bubbles.
    always_comb begin
        outstanding = 8'(fifo_cnt) - 8'(pop);
        for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
            outstanding = outstanding + 8'(rd_pipe[i]);
        end
    end

    always_comb begin
        issue      = 1'b0;
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    issue      = (outstanding < 8'd4);
                    state_next = READ;
                end
            end
            READ:  issue = (outstanding < 8'd4);
            FLUSH: if (pop && beat_cnt == LAST_ADDR) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (issue && addr_cnt == LAST_ADDR) state_next = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_pipe  <= '0;
            addr_q   <= '0;
            addr_cnt <= '0;
            beat_cnt <= '0;
            col_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            state   <= state_next;
            rd_pipe <= {rd_pipe[READ_LATENCY-1:0], issue};
            addr_q  <= issue ? addr_cnt : '0;

            if (state == DONE) begin
                addr_cnt <= '0;
            end else if (issue) begin
                addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            end

            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);

            if (state == DONE) begin
                beat_cnt <= '0;
                col_cnt  <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
                col_cnt  <= (col_cnt == LAST_COL) ? '0 : col_cnt + COL_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.bram_dout;
    end

    assign bus.bram_en    = rd_pipe[0];
    assign bus.bram_addr  = addr_q;
    assign bus.m_valid    = fifo_valid;
    assign bus.m_data     = fifo_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.m_row_last = fifo_valid && (col_cnt == LAST_COL);
    assign bus.m_last     = fifo_valid && (beat_cnt == LAST_ADDR);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
endmodule

// File: tb/tb_output_bram_streamer.sv
// Bench for output_bram_streamer: a default 126x126 instance driven through
// full-frame, stall, random-ready and reset scenarios, plus a 4x3 instance.
module tb_output_bram_streamer;
    localparam int W = 126;
    localparam int N = 126 * 126;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic s_start, s_busy, s_done;
    int   errors = 0;
    int   checks = 0;

    output_bram_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) bif ();
    output_bram_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  sif ();

    output_bram_streamer dut (
        .clk(clk), .rst(rst), .start(start), .bus(bif), .busy(busy), .done(done)
    );

    output_bram_streamer #(
        .OUT_WIDTH(4), .OUT_HEIGHT(3), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2)
    ) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .bus(sif), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    // Two-stage BRAM models preloaded with mem[i] = i.
    logic [13:0] b_a1;
    logic [3:0]  s_a1;
    always @(posedge clk) begin
        b_a1          <= bif.bram_addr;
        bif.bram_dout <= 32'(b_a1);
        s_a1          <= sif.bram_addr;
        sif.bram_dout <= 32'(s_a1);
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bram_en"},    64'(bif.bram_en),    64'd0);
        check({tag, "_bram_addr"},  64'(bif.bram_addr),  64'd0);
        check({tag, "_m_data"},     64'(bif.m_data),     64'd0);
        check({tag, "_m_valid"},    64'(bif.m_valid),    64'd0);
        check({tag, "_m_row_last"}, 64'(bif.m_row_last), 64'd0);
        check({tag, "_m_last"},     64'(bif.m_last),     64'd0);
        check({tag, "_busy"},       64'(busy),           64'd0);
        check({tag, "_done"},       64'(done),           64'd0);
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for the first 100 cycles.
    // abort_at >= 0 pulses rst once that many beats have been accepted.
    task automatic run_frame(input int mode, input bit inject, input int abort_at);
        int beats = 0, reads = 0, first_valid = -1, last_k = -1;
        int done_seen = 0, max_out = 0, post = 0;
        logic [31:0] held_data = '0;
        logic [33:0] exp_beat;
        bit held = 0, finished = 0, rdy;
        for (int k = 0; k < 70000 && !finished; k++) begin
            @(negedge clk);
            if (abort_at >= 0 && beats == abort_at) begin
                rst = 1'b1;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_reset_values("abort");
                for (int j = 0; j < 8; j++) begin
                    @(negedge clk);
                    check("abort_quiet", 64'({bif.m_valid, bif.bram_en, busy}), 64'd0);
                end
                finished = 1;
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = (k > 100);
                endcase
                bif.m_ready = rdy;
                if (bif.bram_en) begin
                    check("bram_addr", 64'(bif.bram_addr), 64'(reads));
                    reads++;
                end else begin
                    check("bram_addr_idle", 64'(bif.bram_addr), 64'd0);
                end
                if (reads - beats > max_out) max_out = reads - beats;
                if (held) check("stall_hold", 64'({bif.m_valid, bif.m_data}), 64'({1'b1, held_data}));
                if (mode == 0 && first_valid >= 0 && beats < N)
                    check("no_bubble", 64'(bif.m_valid), 64'd1);
                if (bif.m_valid) begin
                    if (first_valid < 0) begin
                        first_valid = k - 1;
                        check("first_valid_latency", 64'(first_valid), 64'd3);
                    end
                    exp_beat = {32'(beats), (beats % W) == W - 1, beats == N - 1};
                    check("beat", 64'({bif.m_data, bif.m_row_last, bif.m_last}), 64'(exp_beat));
                end
                if (mode == 2 && k == 100) check("stalled_reads", 64'(reads), 64'd4);
                held      = bif.m_valid && !rdy;
                held_data = bif.m_data;
                if (bif.m_valid && rdy) begin
                    beats++;
                    last_k = k;
                end
                if (done) begin
                    done_seen++;
                    check("done_after_last", 64'(k), 64'(last_k + 1));
                    check("done_beats", 64'(beats), 64'(N));
                end else if (done_seen > 0) begin
                    check("idle_after_done", 64'({busy, bif.m_valid}), 64'd0);
                    post++;
                end
                if (post >= 6) finished = 1;
                start = (k == 0) || (inject && (k == 300 || done));
            end
        end
        start = 1'b0;
        check("frame_complete", 64'(finished), 64'd1);
        if (abort_at < 0) begin
            check("done_once", 64'(done_seen), 64'd1);
            check("total_beats", 64'(beats), 64'(N));
            check("total_reads", 64'(reads), 64'(N));
            check("max_outstanding_le4", 64'(max_out <= 4), 64'd1);
        end
    endtask

    typedef struct {
        int          stall;
        logic [31:0] data;
        logic        row_last;
        logic        last;
    } vec_t;

    vec_t vecs [12];

    task automatic run_small();
        int dcount;
        @(negedge clk);
        s_start = 1'b1;
        sif.m_ready = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        for (int w = 0; w < 20 && !sif.m_valid; w++) @(negedge clk);
        check("small_first_valid", 64'(sif.m_valid), 64'd1);
        for (int i = 0; i < 12; i++) begin
            sif.m_ready = 1'b0;
            for (int s = 0; s < vecs[i].stall; s++) begin
                check("small_stall", 64'({sif.m_valid, sif.m_data}), 64'({1'b1, vecs[i].data}));
                @(negedge clk);
            end
            sif.m_ready = 1'b1;
            check("small_beat", 64'({sif.m_valid, sif.m_data, sif.m_row_last, sif.m_last}),
                  64'({1'b1, vecs[i].data, vecs[i].row_last, vecs[i].last}));
            @(negedge clk);
        end
        sif.m_ready = 1'b0;
        check("small_done", 64'(s_done), 64'd1);
        dcount = int'(s_done);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (s_done) dcount++;
        end
        check("small_done_once", 64'(dcount), 64'd1);
        check("small_idle", 64'({s_busy, sif.m_valid}), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{0, 32'd0,  1'b0, 1'b0};
        vecs[1]  = '{2, 32'd1,  1'b0, 1'b0};
        vecs[2]  = '{0, 32'd2,  1'b0, 1'b0};
        vecs[3]  = '{1, 32'd3,  1'b1, 1'b0};
        vecs[4]  = '{0, 32'd4,  1'b0, 1'b0};
        vecs[5]  = '{0, 32'd5,  1'b0, 1'b0};
        vecs[6]  = '{3, 32'd6,  1'b0, 1'b0};
        vecs[7]  = '{0, 32'd7,  1'b1, 1'b0};
        vecs[8]  = '{1, 32'd8,  1'b0, 1'b0};
        vecs[9]  = '{0, 32'd9,  1'b0, 1'b0};
        vecs[10] = '{2, 32'd10, 1'b0, 1'b0};
        vecs[11] = '{0, 32'd11, 1'b1, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        bif.m_ready = 1'b0;
        sif.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        run_small();
        run_frame(0, 1'b1, -1);
        run_frame(2, 1'b0, -1);
        run_frame(1, 1'b0, -1);
        run_frame(0, 1'b0, 500);
        run_frame(0, 1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
